uart_frame_packer: RTL and testbench
====================================

// Module: uart_frame_packer
// PURPOSE
//  Parametrised byte-to-word packer with an internal word FIFO and a frame sequencer.
//  Bytes from the UART receive side are packed into WORD_BYTES-wide words and buffered.
//  Words are released to the computation core only in whole frames of FRAME_WORDS words.
//  One clock domain; replaces the dual-clock byte FIFO plus enable polling on the receive path.
// PARAMETERS
//  WORD_BYTES   4   bytes per word (>=1); word width W = 8*WORD_BYTES
//  DEPTH        8   FIFO depth in words; power of 2, >=2
//  FRAME_WORDS  4   words per frame; 1..DEPTH
//  BIG_ENDIAN   1   1: first byte -> Out_word[W-1:W-8]; 0: first byte -> Out_word[7:0]
//  (localparam AW = log2(DEPTH))
// PORTS
//  Clk             in   1     clock
//  Rst_n           in   1     asynchronous active-low reset
//  In_clr          in   1     synchronous clear: drop partial word, FIFO, frame, overflow
//  In_byte_valid   in   1     byte strobe from UART receiver
//  In_byte         in   8     received byte
//  Out_byte_ready  out  1     packer can accept a byte this cycle
//  Out_word_valid  out  1     Out_word holds a word of the current frame
//  Out_word        out  W     packed word (FIFO head, first-word-fall-through)
//  In_word_ready   in   1     consumer accepts Out_word
//  Out_last        out  1     Out_word is the final word of the frame (qualified by valid)
//  Out_frame_start out  1     1-cycle pulse: a full frame is buffered and streaming begins
//  Out_count       out  AW+1  words currently in the FIFO (0..DEPTH)
//  Out_overflow    out  1     sticky: a byte arrived while Out_byte_ready=0 (byte dropped)
// BEHAVIOUR
//  Reset (Rst_n=0, asynchronous): byte_idx=0, accumulator=0, pointers=0, Out_count=0,
//   state=IDLE, frame word counter=0, Out_overflow=0, Out_frame_start=0, Out_word_valid=0, Out_last=0.
//  Packing: byte accepted when In_byte_valid && Out_byte_ready; byte_idx advances 0..WORD_BYTES-1.
//   On the byte at idx WORD_BYTES-1, the assembled word (accumulator + this byte) is written
//   to the FIFO in the same edge; byte_idx -> 0. No extra latency beyond that edge.
//   Order per BIG_ENDIAN; WORD_BYTES=1 means every byte is one push.
//  Out_byte_ready = (byte_idx != WORD_BYTES-1) || (Out_count < DEPTH); registered terms only,
//   no combinational path from In_word_ready. Partial bytes are accepted even when the FIFO is full.
//  Overflow: In_byte_valid && !Out_byte_ready -> byte dropped, Out_overflow=1 until In_clr/reset.
//  FIFO: pop when Out_word_valid && In_word_ready. Push+pop same cycle -> count unchanged.
//   Pointers are AW bits and wrap DEPTH-1 -> 0. Push never occurs at count==DEPTH.
//  Frame FSM:
//   IDLE: Out_word_valid=0. If Out_count >= FRAME_WORDS -> STREAM, Out_frame_start=1 for 1 cycle
//    (the cycle after the condition holds), frame counter=0.
//   STREAM: Out_word_valid = (Out_count != 0), which always holds in STREAM.
//    Each pop increments the frame counter. Out_last = (frame counter == FRAME_WORDS-1).
//    A pop with Out_last=1 -> IDLE next cycle. Re-entry to STREAM needs another full frame
//    (minimum one IDLE cycle between frames).
//   Pushes continue during STREAM; consumer back-pressure (In_word_ready=0) holds Out_word stable.
//  In_clr: highest priority over push/pop in that cycle. All state returns to reset values;
//   a concurrent byte is ignored and does not set overflow. A frame in flight is aborted (no Out_last).
//  Out_count is registered and reflects pushes and pops from the previous edge.
// TESTING
//  T1 WORD_BYTES=4, BIG_ENDIAN=1, 16 bytes 00..0F, ready=1 -> Out_frame_start once;
//     words 00010203, 04050607, 08090A0B, 0C0D0E0F; Out_last on the 4th; then IDLE.
//  T2 BIG_ENDIAN=0, bytes 11 22 33 44 -> word 44332211; after 3 bytes Out_count=0, no frame.
//  T3 ready=0, push 36 bytes -> Out_count=8 after byte 32; bytes 33..35 accepted, byte 36 refused;
//     Out_overflow=1 only with byte 36 valid; raising ready drains two frames in order.
//  T4 wrap/concurrency: continuous byte stream plus consumer ready toggling 1010 for 200 words ->
//     no loss or reorder; Out_count never >8; count steady across same-cycle push+pop.
//  T5 In_clr mid-frame after 2 of 4 pops, with a byte pending -> next cycle count=0,
//     valid=0, overflow=0; subsequent 16 bytes yield a clean frame starting at the new data.
//  T6 assert Rst_n low asynchronously mid-STREAM -> all outputs at reset values before the next Clk edge.

Source files
------------

// File: rtl/uart_frame_packer.sv
// Byte-to-word packer feeding a first-word-fall-through word FIFO.
// Words leave the FIFO only in whole frames of FRAME_WORDS, sequenced by a two-state FSM.
module uart_frame_packer #(
  parameter int WORD_BYTES  = 4,
  parameter int DEPTH       = 8,
  parameter int FRAME_WORDS = 4,
  parameter int BIG_ENDIAN  = 1
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    In_clr,
  input  logic                    In_byte_valid,
  input  logic [7:0]              In_byte,
  output logic                    Out_byte_ready,
  output logic                    Out_word_valid,
  output logic [8*WORD_BYTES-1:0] Out_word,
  input  logic                    In_word_ready,
  output logic                    Out_last,
  output logic                    Out_frame_start,
  output logic [$clog2(DEPTH):0]  Out_count,
  output logic                    Out_overflow
);
  localparam int W   = 8 * WORD_BYTES;
  localparam int AW  = $clog2(DEPTH);
  localparam int IW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int FCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [IW-1:0]  LAST_IDX  = IW'(WORD_BYTES - 1);
  localparam logic [FCW-1:0] LAST_WORD = FCW'(FRAME_WORDS - 1);
  localparam logic [AW:0]    DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    FRAME_C   = (AW + 1)'(FRAME_WORDS);

  typedef enum logic {IDLE, STREAM} state_t;

  logic [IW-1:0]  byte_idx_reg;
  logic [W-1:0]   acc_reg;
  logic [W-1:0]   assembled;
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic           overflow_reg;
  state_t         state_reg, state_next;
  logic [FCW-1:0] frame_cnt_reg, frame_cnt_next;
  logic           frame_start_reg, frame_start_next;
  logic [W-1:0]   mem [DEPTH];

  logic last_byte, accept, push, pop;

  assign last_byte      = (byte_idx_reg == LAST_IDX);
  assign Out_byte_ready = !last_byte || (count_reg < DEPTH_C);
  assign accept         = In_byte_valid && Out_byte_ready && !In_clr;
  assign push           = accept && last_byte;
  assign Out_word_valid = (state_reg == STREAM) && (count_reg != '0);
  assign Out_last       = Out_word_valid && (frame_cnt_reg == LAST_WORD);
  assign pop            = Out_word_valid && In_word_ready && !In_clr;
  assign Out_word       = mem[rd_ptr_reg];
  assign Out_count      = count_reg;
  assign Out_overflow   = overflow_reg;
  assign Out_frame_start = frame_start_reg;

  // Each lane takes the incoming byte when its slot is current, otherwise keeps the accumulator.
  genvar gi;
  for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
    localparam int LANE = (BIG_ENDIAN != 0) ? (WORD_BYTES - 1 - gi) : gi;
    assign assembled[8*LANE +: 8] = (byte_idx_reg == IW'(gi)) ? In_byte : acc_reg[8*LANE +: 8];
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr_reg] <= assembled;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      byte_idx_reg <= '0;
      acc_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (In_clr) begin
      byte_idx_reg <= '0;
      acc_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) begin
        byte_idx_reg <= last_byte ? '0 : byte_idx_reg + 1'b1;
        acc_reg      <= last_byte ? '0 : assembled;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
      if (In_byte_valid && !Out_byte_ready) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg       <= IDLE;
      frame_cnt_reg   <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      frame_cnt_reg   <= frame_cnt_next;
      frame_start_reg <= frame_start_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    frame_cnt_next   = frame_cnt_reg;
    frame_start_next = 1'b0;
    if (state_reg == IDLE) begin
      if (count_reg >= FRAME_C) begin
        state_next       = STREAM;
        frame_cnt_next   = '0;
        frame_start_next = 1'b1;
      end
    end else if (pop) begin
      if (Out_last) begin
        state_next     = IDLE;
        frame_cnt_next = '0;
      end else begin
        frame_cnt_next = frame_cnt_reg + 1'b1;
      end
    end
    // Clear aborts any frame in flight without ever presenting its last word.
    if (In_clr) begin
      state_next       = IDLE;
      frame_cnt_next   = '0;
      frame_start_next = 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_frame_packer.sv
// Self-checking bench for uart_frame_packer: cycle model plus word scoreboard,
// with a second little-endian instance for byte-order checks.
module tb_uart_frame_packer;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        In_clr = 1'b0, In_byte_valid = 1'b0, In_word_ready = 1'b0;
  logic [7:0]  In_byte = 8'h00;
  logic        Out_byte_ready, Out_word_valid, Out_last, Out_frame_start, Out_overflow;
  logic [31:0] Out_word;
  logic [3:0]  Out_count;

  logic        le_clr = 1'b0, le_bv = 1'b0, le_wr = 1'b1;
  logic [7:0]  le_b = 8'h00;
  logic        le_ready, le_valid, le_last, le_fs, le_ovf;
  logic [31:0] le_word;
  logic [3:0]  le_count;

  always #5 Clk = ~Clk;

  uart_frame_packer #(.WORD_BYTES(4), .DEPTH(8), .FRAME_WORDS(4), .BIG_ENDIAN(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_clr(In_clr), .In_byte_valid(In_byte_valid), .In_byte(In_byte),
    .Out_byte_ready(Out_byte_ready), .Out_word_valid(Out_word_valid), .Out_word(Out_word),
    .In_word_ready(In_word_ready), .Out_last(Out_last), .Out_frame_start(Out_frame_start),
    .Out_count(Out_count), .Out_overflow(Out_overflow));

  uart_frame_packer #(.WORD_BYTES(4), .DEPTH(8), .FRAME_WORDS(4), .BIG_ENDIAN(0)) dut_le (
    .Clk(Clk), .Rst_n(Rst_n), .In_clr(le_clr), .In_byte_valid(le_bv), .In_byte(le_b),
    .Out_byte_ready(le_ready), .Out_word_valid(le_valid), .Out_word(le_word),
    .In_word_ready(le_wr), .Out_last(le_last), .Out_frame_start(le_fs),
    .Out_count(le_count), .Out_overflow(le_ovf));

  int n_checks = 0, n_pass = 0;
  logic [31:0] sb[$];

  // reference model state (values the DUT registers should hold after the last edge)
  int m_idx, m_cnt, m_fcnt;
  logic [31:0] m_acc;
  bit m_stream, m_ovf, m_fs;

  // observations taken just before the edge of the last drive() call
  logic obs_valid, obs_last, obs_ready, obs_pop;
  logic [31:0] obs_word, exp_word;
  bit exp_valid, exp_last, exp_ready;

  task automatic model_reset();
    m_idx = 0; m_cnt = 0; m_fcnt = 0; m_acc = '0;
    m_stream = 0; m_ovf = 0; m_fs = 0;
    sb.delete();
  endtask

  task automatic drive(input bit clr, input bit bv, input logic [7:0] b, input bit wr);
    bit acc, push, pop;
    int cnt0;
    In_clr = clr; In_byte_valid = bv; In_byte = b; In_word_ready = wr;
    obs_valid = Out_word_valid; obs_last = Out_last; obs_ready = Out_byte_ready; obs_word = Out_word;
    exp_ready = (m_idx != 3) || (m_cnt < 8);
    exp_valid = m_stream && (m_cnt != 0);
    exp_last  = exp_valid && (m_fcnt == 3);
    obs_pop   = obs_valid && wr && !clr;
    exp_word  = 'x;
    if (obs_pop && sb.size() > 0) exp_word = sb.pop_front();
    if (clr) begin
      model_reset();
    end else begin
      acc  = bv && exp_ready;
      push = acc && (m_idx == 3);
      pop  = exp_valid && wr;
      if (bv && !exp_ready) m_ovf = 1;
      if (acc) begin
        m_acc[31-8*m_idx -: 8] = b;
        if (push) begin sb.push_back(m_acc); m_acc = '0; m_idx = 0; end
        else m_idx++;
      end
      cnt0 = m_cnt;
      m_cnt = m_cnt + int'(push) - int'(pop);
      m_fs = 0;
      if (!m_stream) begin
        if (cnt0 >= 4) begin m_stream = 1; m_fcnt = 0; m_fs = 1; end
      end else if (pop) begin
        if (m_fcnt == 3) begin m_stream = 0; m_fcnt = 0; end
        else m_fcnt++;
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    #7;
    n_checks++; if (Out_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", Out_count); else n_pass++;
    n_checks++; if (Out_word_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", Out_word_valid); else n_pass++;
    n_checks++; if (Out_last !== 1'b0 || Out_frame_start !== 1'b0) $display("FAIL reset_last_fs: got %b%b expected 00", Out_last, Out_frame_start); else n_pass++;
    n_checks++; if (Out_overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", Out_overflow); else n_pass++;
    n_checks++; if (Out_byte_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", Out_byte_ready); else n_pass++;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    model_reset();
    @(posedge Clk); #1;
    $display("test_reset done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_frame();
    logic [31:0] got[$];
    int fs_n = 0, last_n = 0, last_at = -1;
    for (int c = 0; c < 30; c++) begin
      drive(0, c < 16, 8'(c), 1);
      if (obs_pop) begin
        got.push_back(obs_word);
        n_checks++; if (obs_word !== exp_word) $display("FAIL t1_word: got %h expected %h", obs_word, exp_word); else n_pass++;
        if (obs_last) begin last_n++; last_at = got.size(); end
      end
      n_checks++; if (obs_valid !== exp_valid || obs_last !== exp_last) $display("FAIL t1_valid_last: got %b%b expected %b%b", obs_valid, obs_last, exp_valid, exp_last); else n_pass++;
      n_checks++; if (Out_count !== 4'(m_cnt)) $display("FAIL t1_count: got %0d expected %0d", Out_count, m_cnt); else n_pass++;
      if (Out_frame_start === 1'b1) fs_n++;
    end
    n_checks++; if (got.size() != 4) $display("FAIL t1_npop: got %0d expected 4", got.size()); else n_pass++;
    if (got.size() == 4) begin
      n_checks++; if (got[0] !== 32'h00010203 || got[1] !== 32'h04050607 || got[2] !== 32'h08090A0B || got[3] !== 32'h0C0D0E0F)
        $display("FAIL t1_words: got %h %h %h %h expected 00010203 04050607 08090a0b 0c0d0e0f", got[0], got[1], got[2], got[3]); else n_pass++;
    end
    n_checks++; if (fs_n != 1) $display("FAIL t1_frame_start: got %0d pulses expected 1", fs_n); else n_pass++;
    n_checks++; if (last_n != 1 || last_at != 4) $display("FAIL t1_last: got %0d at pop %0d expected 1 at pop 4", last_n, last_at); else n_pass++;
    n_checks++; if (Out_word_valid !== 1'b0) $display("FAIL t1_idle: got valid %b expected 0", Out_word_valid); else n_pass++;
    $display("test_frame done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_little_endian();
    logic [7:0] lb [16];
    logic [31:0] got[$];
    logic smp;
    logic [31:0] w;
    lb[0] = 8'h11; lb[1] = 8'h22; lb[2] = 8'h33; lb[3] = 8'h44;
    for (int i = 4; i < 16; i++) lb[i] = 8'h4C + 8'(i);
    le_wr = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 3) begin
        n_checks++; if (le_count !== 4'd0 || le_valid !== 1'b0 || le_fs !== 1'b0) $display("FAIL t2_partial: got count %0d valid %b fs %b expected 0 0 0", le_count, le_valid, le_fs); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (le_count !== 4'd1 || le_valid !== 1'b0) $display("FAIL t2_one_word: got count %0d valid %b expected 1 0", le_count, le_valid); else n_pass++;
      end
      le_bv = (c < 16);
      le_b  = (c < 16) ? lb[c] : 8'h00;
      smp = le_valid && le_wr;
      w = le_word;
      @(posedge Clk); #1;
      if (smp) got.push_back(w);
    end
    le_bv = 1'b0;
    n_checks++; if (got.size() != 4) $display("FAIL t2_npop: got %0d expected 4", got.size()); else n_pass++;
    if (got.size() >= 2) begin
      n_checks++; if (got[0] !== 32'h44332211) $display("FAIL t2_word0: got %h expected 44332211", got[0]); else n_pass++;
      n_checks++; if (got[1] !== 32'h53525150) $display("FAIL t2_word1: got %h expected 53525150", got[1]); else n_pass++;
    end
    $display("test_little_endian done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_overflow();
    int pops = 0, lasts = 0;
    logic [31:0] first = 'x;
    for (int k = 1; k <= 36; k++) begin
      drive(0, 1, 8'(k), 0);
      if (k == 32) begin
        n_checks++; if (Out_count !== 4'd8) $display("FAIL t3_full: got %0d expected 8", Out_count); else n_pass++;
      end
      if (k >= 33 && k <= 35) begin
        n_checks++; if (obs_ready !== 1'b1 || Out_overflow !== 1'b0) $display("FAIL t3_partial_ok: byte %0d ready %b ovf %b expected 1 0", k, obs_ready, Out_overflow); else n_pass++;
      end
      if (k == 36) begin
        n_checks++; if (obs_ready !== 1'b0) $display("FAIL t3_refuse: got ready %b expected 0", obs_ready); else n_pass++;
        n_checks++; if (Out_overflow !== 1'b1) $display("FAIL t3_ovf: got %b expected 1", Out_overflow); else n_pass++;
      end
      n_checks++; if (obs_ready !== exp_ready) $display("FAIL t3_ready: got %b expected %b", obs_ready, exp_ready); else n_pass++;
    end
    for (int c = 0; c < 40; c++) begin
      drive(0, 0, 8'h00, 1);
      if (obs_pop) begin
        if (pops == 0) first = obs_word;
        pops++;
        if (obs_last) lasts++;
        n_checks++; if (obs_word !== exp_word) $display("FAIL t3_word: got %h expected %h", obs_word, exp_word); else n_pass++;
      end
    end
    n_checks++; if (pops != 8 || lasts != 2) $display("FAIL t3_drain: got %0d pops %0d lasts expected 8 2", pops, lasts); else n_pass++;
    n_checks++; if (first !== 32'h01020304) $display("FAIL t3_first: got %h expected 01020304", first); else n_pass++;
    n_checks++; if (Out_count !== 4'd0 || Out_overflow !== 1'b1) $display("FAIL t3_after: got count %0d ovf %b expected 0 1", Out_count, Out_overflow); else n_pass++;
    drive(1, 0, 8'h00, 0);
    n_checks++; if (Out_overflow !== 1'b0) $display("FAIL t3_clr_ovf: got %b expected 0", Out_overflow); else n_pass++;
    $display("test_overflow done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_back_to_back();
    int pops = 0, maxc = 0, cyc = 0;
    while (pops < 200 && cyc < 3000) begin
      drive(0, 1, 8'($urandom_range(0, 255)), (cyc % 2) == 0);
      cyc++;
      if (obs_pop) begin
        pops++;
        n_checks++; if (obs_word !== exp_word) $display("FAIL t4_word: pop %0d got %h expected %h", pops, obs_word, exp_word); else n_pass++;
      end
      if (int'(Out_count) > maxc) maxc = int'(Out_count);
      n_checks++; if (Out_count !== 4'(m_cnt)) $display("FAIL t4_count: cycle %0d got %0d expected %0d", cyc, Out_count, m_cnt); else n_pass++;
    end
    n_checks++; if (pops < 200) $display("FAIL t4_timeout: got %0d pops expected 200", pops); else n_pass++;
    n_checks++; if (maxc > 8) $display("FAIL t4_maxcount: got %0d expected <=8", maxc); else n_pass++;
    drive(1, 0, 8'h00, 0);
    $display("test_back_to_back done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_clear();
    int pops = 0, fs_n = 0, last_n = 0;
    logic [31:0] got[$];
    for (int i = 0; i < 16; i++) drive(0, 1, 8'h80 + 8'(i), 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    for (int c = 0; c < 10 && pops < 2; c++) begin
      drive(0, 0, 8'h00, 1);
      if (obs_pop) pops++;
    end
    n_checks++; if (pops != 2) $display("FAIL t5_prepops: got %0d expected 2", pops); else n_pass++;
    drive(0, 1, 8'hEE, 0);
    drive(0, 1, 8'hEF, 0);
    drive(1, 1, 8'hFF, 1);
    n_checks++; if (Out_count !== 4'd0 || Out_word_valid !== 1'b0) $display("FAIL t5_clr: got count %0d valid %b expected 0 0", Out_count, Out_word_valid); else n_pass++;
    n_checks++; if (Out_overflow !== 1'b0 || Out_last !== 1'b0 || Out_frame_start !== 1'b0) $display("FAIL t5_clr_flags: got ovf %b last %b fs %b expected 000", Out_overflow, Out_last, Out_frame_start); else n_pass++;
    for (int c = 0; c < 30; c++) begin
      drive(0, c < 16, 8'hA0 + 8'(c), 1);
      if (obs_pop) begin
        got.push_back(obs_word);
        if (obs_last) last_n++;
        n_checks++; if (obs_word !== exp_word) $display("FAIL t5_word: got %h expected %h", obs_word, exp_word); else n_pass++;
      end
      if (Out_frame_start === 1'b1) fs_n++;
    end
    n_checks++; if (got.size() != 4 || fs_n != 1 || last_n != 1) $display("FAIL t5_frame: got %0d pops %0d fs %0d last expected 4 1 1", got.size(), fs_n, last_n); else n_pass++;
    if (got.size() == 4) begin
      n_checks++; if (got[0] !== 32'hA0A1A2A3 || got[3] !== 32'hACADAEAF) $display("FAIL t5_words: got %h %h expected a0a1a2a3 acadaeaf", got[0], got[3]); else n_pass++;
    end
    $display("test_clear done: %0d/%0d", n_pass, n_checks);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) drive(0, 1, 8'(i), 0);
    drive(0, 1, 8'h55, 0);
    drive(0, 0, 8'h00, 0);
    n_checks++; if (Out_word_valid !== 1'b1) $display("FAIL t6_pre: got valid %b expected 1", Out_word_valid); else n_pass++;
    #3 Rst_n = 1'b0;
    #1;
    n_checks++; if (Out_word_valid !== 1'b0 || Out_last !== 1'b0 || Out_frame_start !== 1'b0) $display("FAIL t6_async_flags: got valid %b last %b fs %b expected 000", Out_word_valid, Out_last, Out_frame_start); else n_pass++;
    n_checks++; if (Out_count !== 4'd0 || Out_overflow !== 1'b0 || Out_byte_ready !== 1'b1) $display("FAIL t6_async_state: got count %0d ovf %b ready %b expected 0 0 1", Out_count, Out_overflow, Out_byte_ready); else n_pass++;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) drive(0, 1, 8'hC0 + 8'(i), 0);
    n_checks++; if (Out_count !== 4'd1) $display("FAIL t6_restart: got count %0d expected 1", Out_count); else n_pass++;
    $display("test_async_reset done: %0d/%0d", n_pass, n_checks);
  endtask

  initial begin
    #1;
    test_reset();
    test_frame();
    test_little_endian();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
